// File: rtl/exec_controller.sv
// Front-panel execute conditioner: synchronises and debounces the button, then
// runs the run/stop and single-step state machine that drives exec to control_unit.
module exec_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic       step_mode,
    input  logic [2:0] phase,
    input  logic       halt,
    output logic       exec,
    output logic       running,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP_A = 2'd2,
        STEP_B = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        btn_db_q, btn_db_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic        btn_q, btn_d;
    logic [7:0]  press_count_q, press_count_d;
    state_t      state_q, state_d;
    logic        press;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            db_cnt_q      <= '0;
            btn_q         <= 1'b0;
            press_count_q <= '0;
            state_q       <= IDLE;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            btn_db_q      <= btn_db_d;
            db_cnt_q      <= db_cnt_d;
            btn_q         <= btn_d;
            press_count_q <= press_count_d;
            state_q       <= state_d;
        end
    end

    // Any disagreement shorter than the debounce window restarts the count.
    always_comb begin
        sync1_d  = button;
        sync2_d  = sync1_q;
        btn_db_d = btn_db_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 16'd1;
        end
        btn_d         = btn_db_q;
        press         = btn_db_q & ~btn_q;
        press_count_d = press ? press_count_q + 8'd1 : press_count_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (press && !halt) begin
                    state_d = step_mode ? STEP_A : RUN;
                end
            end
            RUN: begin
                if (halt || press) begin
                    state_d = IDLE;
                end
            end
            STEP_A: begin
                if (halt) begin
                    state_d = IDLE;
                end else if (phase == 3'd4) begin
                    state_d = STEP_B;
                end
            end
            STEP_B: begin
                if (halt || phase != 3'd4) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign exec        = (state_q != IDLE);
    assign running     = (state_q == RUN);
    assign press_count = press_count_q;

endmodule

// File: tb/tb_exec_controller.sv
// Directed self-checking bench for exec_controller with a short debounce window.
module tb_exec_controller;

    localparam int unsigned D = 4;

    logic       clock;
    logic       reset;
    logic       button;
    logic       step_mode;
    logic [2:0] phase;
    logic       halt;
    logic       exec;
    logic       running;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    exec_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .button      (button),
        .step_mode   (step_mode),
        .phase       (phase),
        .halt        (halt),
        .exec        (exec),
        .running     (running),
        .press_count (press_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Set the button level just after an edge and wait until its effect has settled.
    task automatic set_button(input logic level);
        button = level;
        for (int i = 0; i < int'(D) + 3; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; button = 1'b0; step_mode = 1'b0; phase = 3'd0; halt = 1'b0;
        #2;
        checks++;
        if (exec !== 1'b0 || running !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state exec=%b running=%b count=%0d required 0 0 0", exec, running, press_count);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_glitch();
        button = 1'b1;
        for (int i = 0; i < int'(D) - 1; i++) tick();
        button = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (exec !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL glitch_reject exec=%b count=%0d required 0 0", exec, press_count);
        end
    endtask

    task automatic test_run_press();
        step_mode = 1'b0;
        button = 1'b1;
        for (int i = 1; i <= int'(D) + 3; i++) begin
            tick();
            if (i == int'(D) + 2) begin
                checks++;
                if (exec !== 1'b0) begin
                    errors++;
                    $display("FAIL run_latency_early exec=%b required 0", exec);
                end
            end
            if (i == int'(D) + 3) begin
                checks++;
                if (exec !== 1'b1 || running !== 1'b1 || press_count !== 8'd1) begin
                    errors++;
                    $display("FAIL run_start exec=%b running=%b count=%0d required 1 1 1", exec, running, press_count);
                end
            end
        end
    endtask

    task automatic test_run_stop();
        set_button(1'b0);
        checks++;
        if (running !== 1'b1 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL release_no_action running=%b count=%0d required 1 1", running, press_count);
        end
        button = 1'b1;
        for (int i = 1; i <= int'(D) + 3; i++) begin
            tick();
            if (i == int'(D) + 2) begin
                checks++;
                if (exec !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_latency_early exec=%b required 1", exec);
                end
            end
            if (i == int'(D) + 3) begin
                checks++;
                if (exec !== 1'b0 || running !== 1'b0 || press_count !== 8'd2) begin
                    errors++;
                    $display("FAIL run_stop exec=%b running=%b count=%0d required 0 0 2", exec, running, press_count);
                end
            end
        end
        set_button(1'b0);
    endtask

    task automatic test_halt_press();
        set_button(1'b1);
        set_button(1'b0);
        checks++;
        if (running !== 1'b1 || press_count !== 8'd3) begin
            errors++;
            $display("FAIL rerun running=%b count=%0d required 1 3", running, press_count);
        end
        // halt high exactly in the cycle the press pulse is seen
        button = 1'b1;
        for (int i = 1; i <= int'(D) + 3; i++) begin
            tick();
            halt = (i == int'(D) + 2);
        end
        checks++;
        if (exec !== 1'b0 || running !== 1'b0 || press_count !== 8'd4) begin
            errors++;
            $display("FAIL halt_and_press exec=%b running=%b count=%0d required 0 0 4", exec, running, press_count);
        end
        set_button(1'b0);
        halt = 1'b1;
        set_button(1'b1);
        checks++;
        if (exec !== 1'b0 || press_count !== 8'd5) begin
            errors++;
            $display("FAIL idle_halt_press exec=%b count=%0d required 0 5", exec, press_count);
        end
        halt = 1'b0;
        set_button(1'b0);
        checks++;
        if (exec !== 1'b0) begin
            errors++;
            $display("FAIL idle_halt_release exec=%b required 0", exec);
        end
    endtask

    task automatic test_single_step();
        logic exp;
        step_mode = 1'b1;
        phase = 3'd1;
        button = 1'b1;
        for (int i = 1; i <= int'(D) + 8; i++) begin
            tick();
            if (i >= int'(D) + 2) begin
                exp = (i >= int'(D) + 3) && (i <= int'(D) + 5);
                checks++;
                if (exec !== exp || running !== 1'b0) begin
                    errors++;
                    $display("FAIL single_step_cycle%0d phase=%0d exec=%b running=%b required exec %b running 0",
                             i, phase, exec, running, exp);
                end
            end
            if (i == int'(D) + 4) step_mode = 1'b0;
            phase = 3'((1 + i) % 5);
        end
        checks++;
        if (press_count !== 8'd6) begin
            errors++;
            $display("FAIL single_step_count count=%0d required 6", press_count);
        end
        set_button(1'b0);
    endtask

    task automatic test_async_reset();
        step_mode = 1'b1;
        phase = 3'd0;
        set_button(1'b1);
        set_button(1'b0);
        checks++;
        if (exec !== 1'b1 || press_count !== 8'd7) begin
            errors++;
            $display("FAIL step_hold exec=%b count=%0d required 1 7", exec, press_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (exec !== 1'b0 || running !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset exec=%b running=%b count=%0d required 0 0 0", exec, running, press_count);
        end
        #1;
        reset = 1'b0;
        step_mode = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        for (int n = 1; n <= 256; n++) begin
            set_button(1'b1);
            set_button(1'b0);
            if (n == 255) begin
                checks++;
                if (press_count !== 8'd255 || running !== 1'b1) begin
                    errors++;
                    $display("FAIL count_255 count=%0d running=%b required 255 1", press_count, running);
                end
            end
        end
        checks++;
        if (press_count !== 8'd0 || exec !== 1'b0) begin
            errors++;
            $display("FAIL count_wrap count=%0d exec=%b required 0 0", press_count, exec);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_run_press();
        test_run_stop();
        test_halt_press();
        test_single_step();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
